// File: rtl/snax_tcdm_bank_arbiter.sv
// Round-robin arbiter that shares one TCDM bank between write-only and read-only
// requesters and routes in-order read responses back through an ID FIFO.
module snax_tcdm_bank_arbiter #(
  parameter int unsigned NumWr          = 2,
  parameter int unsigned NumRd          = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned StrbWidth     = DataWidth / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumWr-1:0]               wr_valid_i,
  output logic [NumWr-1:0]               wr_ready_o,
  input  logic [NumWr*AddrWidth-1:0]     wr_addr_i,
  input  logic [NumWr*DataWidth-1:0]     wr_data_i,
  input  logic [NumWr*StrbWidth-1:0]     wr_strb_i,
  input  logic [NumRd-1:0]               rd_valid_i,
  output logic [NumRd-1:0]               rd_ready_o,
  input  logic [NumRd*AddrWidth-1:0]     rd_addr_i,
  output logic [NumRd-1:0]               rd_rsp_valid_o,
  output logic [DataWidth-1:0]           rd_rsp_data_o,
  output logic                           mem_req_o,
  input  logic                           mem_gnt_i,
  output logic                           mem_we_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [StrbWidth-1:0]           mem_be_o,
  input  logic                           mem_rvalid_i,
  input  logic [DataWidth-1:0]           mem_rdata_i,
  output logic                           err_o
);

  localparam int          N      = int'(NumWr + NumRd);
  localparam int unsigned IdxW   = $clog2(N);
  localparam int unsigned RdIdxW = (NumRd > 1) ? $clog2(NumRd) : 1;
  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

  logic [N-1:0]      valid_all, eligible;
  logic [IdxW-1:0]   ptr_q, lock_idx_q, sel_idx, cur_idx;
  logic              lock_q, sel_found, lock_hold, lock_drop, req, hs, is_rd;
  logic [RdIdxW-1:0] fifo_q [MaxOutstanding];
  logic [RdIdxW-1:0] head;
  logic [PtrW-1:0]   fifo_wr_q, fifo_rd_q;
  logic [CntW-1:0]   cnt_q;
  logic              push, pop, err_q;

  assign valid_all = {rd_valid_i, wr_valid_i};

  // Reads are throttled by free ID FIFO slots; writes never are.
  for (genvar g = 0; g < N; g++) begin : g_elig
    if (g < NumWr) begin : g_wr
      assign eligible[g] = valid_all[g];
    end else begin : g_rd
      assign eligible[g] = valid_all[g] && (cnt_q < CntW'(MaxOutstanding));
    end
  end

  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr_q) + off) % N;
      if (!sel_found && eligible[IdxW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // A stalled request stays locked; a locked requester that lets go is an error.
  assign lock_hold = lock_q && valid_all[lock_idx_q];
  assign lock_drop = lock_q && !valid_all[lock_idx_q];
  assign cur_idx   = lock_hold ? lock_idx_q : sel_idx;
  assign req       = rst_ni && (lock_hold || sel_found);
  assign hs        = req && mem_gnt_i;
  assign is_rd     = (cur_idx >= IdxW'(NumWr));

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    wr_ready_o  = '0;
    rd_ready_o  = '0;
    for (int i = 0; i < NumWr; i++) begin
      if (cur_idx == IdxW'(i)) begin
        mem_addr_o    = wr_addr_i[i*AddrWidth +: AddrWidth];
        mem_wdata_o   = wr_data_i[i*DataWidth +: DataWidth];
        mem_be_o      = wr_strb_i[i*StrbWidth +: StrbWidth];
        wr_ready_o[i] = hs;
      end
    end
    for (int j = 0; j < NumRd; j++) begin
      if (cur_idx == IdxW'(NumWr + j)) begin
        mem_addr_o    = rd_addr_i[j*AddrWidth +: AddrWidth];
        mem_be_o      = '1;
        rd_ready_o[j] = hs;
      end
    end
  end

  assign mem_req_o = req;
  assign mem_we_o  = !is_rd;

  assign push = hs && is_rd;
  assign pop  = mem_rvalid_i && (cnt_q != '0);
  assign head = fifo_q[fifo_rd_q];

  always_comb begin
    rd_rsp_valid_o = '0;
    for (int j = 0; j < NumRd; j++) begin
      if (pop && head == RdIdxW'(j)) rd_rsp_valid_o[j] = 1'b1;
    end
  end

  assign rd_rsp_data_o = mem_rdata_i;
  assign err_o         = err_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        ptr_q  <= (cur_idx == IdxW'(N - 1)) ? '0 : cur_idx + 1'b1;
        lock_q <= 1'b0;
      end else begin
        lock_q     <= req;
        lock_idx_q <= cur_idx;
      end
      if (push) fifo_wr_q <= ptr_inc(fifo_wr_q);
      if (pop)  fifo_rd_q <= ptr_inc(fifo_rd_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (lock_drop || (mem_rvalid_i && cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: ID storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[fifo_wr_q] <= RdIdxW'(cur_idx - IdxW'(NumWr));
  end

endmodule

// File: tb/tb_snax_tcdm_bank_arbiter.sv
// Bench for snax_tcdm_bank_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_snax_tcdm_bank_arbiter;
  localparam int NW = 2, NR = 2, AW = 32, DW = 64, SW = DW / 8, MO = 2, N = NW + NR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NW-1:0]    wr_valid = '0, wr_ready;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NW*SW-1:0] wr_strb = '0;
  logic [NR-1:0]    rd_valid = '0, rd_ready, rd_rsp_valid;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [DW-1:0]    rd_rsp_data;
  logic             mem_req, mem_we, err;
  logic             mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata = '0;
  logic [SW-1:0]    mem_be;

  always #5 clk = ~clk;

  snax_tcdm_bank_arbiter #(
    .NumWr(NW), .NumRd(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_rsp_valid_o(rd_rsp_valid), .rd_rsp_data_o(rd_rsp_data),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_ptr = 0;
  bit m_locked = 0;
  int m_lock_idx = 0;
  int m_q[$];
  bit m_err = 0;

  // Last observed outputs, for directed checks
  logic [NW-1:0] last_wr_ready;
  logic [NR-1:0] last_rd_ready, last_rsp;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_rdata;
  logic          last_we, last_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model.
  task automatic step();
    logic [N-1:0]  v;
    logic [NW-1:0] e_wr;
    logic [NR-1:0] e_rd, e_rsp;
    int cur, k;
    bit exp_req, exp_hs;
    @(negedge clk); #1;
    v = {rd_valid, wr_valid};
    exp_req = 0;
    cur = 0;
    if (m_locked && v[m_lock_idx]) begin
      exp_req = 1;
      cur = m_lock_idx;
    end else begin
      for (int off = 0; off < N; off++) begin
        k = (m_ptr + off) % N;
        if (v[k] && (k < NW || m_q.size() < MO)) begin
          exp_req = 1;
          cur = k;
          break;
        end
      end
    end
    exp_hs = exp_req && mem_gnt;
    e_wr = '0; e_rd = '0; e_rsp = '0;
    if (exp_hs) begin
      if (cur < NW) e_wr[cur] = 1'b1;
      else          e_rd[cur-NW] = 1'b1;
    end
    if (mem_rvalid && m_q.size() > 0) e_rsp[m_q[0]] = 1'b1;

    check("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) begin
      check("mem_we", 64'(mem_we), 64'(cur < NW));
      if (cur < NW) begin
        check("mem_addr_wr", 64'(mem_addr), 64'(wr_addr[cur*AW +: AW]));
        check("mem_wdata", mem_wdata, wr_data[cur*DW +: DW]);
        check("mem_be_wr", 64'(mem_be), 64'(wr_strb[cur*SW +: SW]));
      end else begin
        check("mem_addr_rd", 64'(mem_addr), 64'(rd_addr[(cur-NW)*AW +: AW]));
        check("mem_be_rd", 64'(mem_be), 64'hFF);
      end
    end
    check("wr_ready", 64'(wr_ready), 64'(e_wr));
    check("rd_ready", 64'(rd_ready), 64'(e_rd));
    check("rsp_valid", 64'(rd_rsp_valid), 64'(e_rsp));
    if (e_rsp != '0) check("rsp_data", rd_rsp_data, mem_rdata);
    check("err", 64'(err), 64'(m_err));

    last_wr_ready = wr_ready;
    last_rd_ready = rd_ready;
    last_rsp      = rd_rsp_valid;
    last_addr     = mem_addr;
    last_rdata    = rd_rsp_data;
    last_we       = mem_we;
    last_err      = err;

    if (m_locked && !v[m_lock_idx]) m_err = 1;
    if (mem_rvalid && m_q.size() == 0) m_err = 1;
    if (mem_rvalid && m_q.size() > 0) void'(m_q.pop_front());
    if (exp_hs) begin
      m_ptr = (cur + 1) % N;
      m_locked = 0;
      if (cur >= NW) m_q.push_back(cur - NW);
    end else begin
      m_locked = exp_req;
      m_lock_idx = cur;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk); #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_ready", 64'(rd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    m_ptr = 0; m_locked = 0; m_q.delete(); m_err = 0;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    wr_valid = '1; rd_valid = '1; mem_gnt = 1'b1;
    do_reset();

    // Two writers, always granted: strict alternation
    wr_valid = 2'b11; rd_valid = '0; mem_gnt = 1'b1; wr_strb = '1;
    wr_addr = {32'h0000_1004, 32'h0000_1000};
    wr_data = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    step(); check("r024_g0", 64'(last_wr_ready), 64'd1); check("r024_we", 64'(last_we), 64'd1);
    step(); check("r024_g1", 64'(last_wr_ready), 64'd2);
    step(); check("r024_g2", 64'(last_wr_ready), 64'd1);
    step(); check("r024_g3", 64'(last_wr_ready), 64'd2);

    // Stalled read stays locked while a write appears
    wr_valid = '0; rd_valid = 2'b01; rd_addr = {32'h80, 32'h40}; mem_gnt = 1'b0;
    step(); check("r025_a0", 64'(last_addr), 64'h40); check("r025_r0", 64'(last_rd_ready), 64'd0);
    wr_valid = 2'b01;
    step(); check("r025_a1", 64'(last_addr), 64'h40); check("r025_r1", 64'(last_rd_ready), 64'd0);
    step(); check("r025_a2", 64'(last_addr), 64'h40); check("r025_r2", 64'(last_rd_ready), 64'd0);
    mem_gnt = 1'b1;
    step(); check("r025_a3", 64'(last_addr), 64'h40); check("r025_r3", 64'(last_rd_ready), 64'd1);
    wr_valid = '0; rd_valid = '0; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    step(); check("r025_rsp", 64'(last_rsp), 64'd1);
    mem_rvalid = 1'b0;

    // Fill the ID FIFO with rd0 then rd1, then a write bypasses the blocked read
    rd_valid = 2'b01;
    step(); check("r026_rd0", 64'(last_rd_ready), 64'd1);
    rd_valid = 2'b10;
    step(); check("r026_rd1", 64'(last_rd_ready), 64'd2);
    rd_valid = 2'b01; wr_valid = 2'b10;
    step(); check("r026_wr1", 64'(last_wr_ready), 64'd2); check("r026_blk", 64'(last_rd_ready), 64'd0);
    wr_valid = '0; mem_rvalid = 1'b1; mem_rdata = 64'hA;
    step(); check("r026_rsp0", 64'(last_rsp), 64'd1); check("r026_dat0", last_rdata, 64'hA);
    check("r027_nogrant", 64'(last_rd_ready), 64'd0);
    mem_rdata = 64'hB;
    step(); check("r026_rsp1", 64'(last_rsp), 64'd2); check("r026_dat1", last_rdata, 64'hB);
    check("r027_grant", 64'(last_rd_ready), 64'd1);
    rd_valid = '0; mem_rdata = 64'hC;
    step(); check("r027_rsp", 64'(last_rsp), 64'd1);
    mem_rvalid = 1'b0;

    // Response with nothing outstanding
    mem_rvalid = 1'b1;
    step(); check("r028_norsp", 64'(last_rsp), 64'd0); check("r028_err0", 64'(last_err), 64'd0);
    mem_rvalid = 1'b0;
    step(); check("r028_err1", 64'(last_err), 64'd1);
    step(); step(); check("r028_sticky", 64'(last_err), 64'd1);

    // Reset with two reads in flight
    rd_valid = 2'b11;
    step(); step();
    wr_valid = 2'b01;
    do_reset();
    step(); check("r029_idx0", 64'(last_wr_ready), 64'd1);
    wr_valid = '0; rd_valid = '0; mem_rvalid = 1'b1;
    step(); check("r029_norsp", 64'(last_rsp), 64'd0);
    mem_rvalid = 1'b0;
    step(); check("r029_err", 64'(last_err), 64'd1);

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 800 == 799) do_reset();
      for (int i = 0; i < NW; i++) begin
        if (wr_valid[i] && !last_wr_ready[i]) begin
          if ($urandom_range(63) == 0) wr_valid[i] = 1'b0;
        end else begin
          wr_valid[i] = 1'($urandom_range(1));
          wr_addr[i*AW +: AW] = $urandom;
          wr_data[i*DW +: DW] = {$urandom, $urandom};
          wr_strb[i*SW +: SW] = SW'($urandom);
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (rd_valid[j] && !last_rd_ready[j]) begin
          if ($urandom_range(63) == 0) rd_valid[j] = 1'b0;
        end else begin
          rd_valid[j] = 1'($urandom_range(1));
          rd_addr[j*AW +: AW] = $urandom;
        end
      end
      mem_gnt    = ($urandom_range(3) != 0);
      mem_rvalid = (m_q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(199) == 0);
      mem_rdata  = {$urandom, $urandom};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snax_tcdm_bank_arbiter.md
SNAX_TCDM_BANK_ARBITER -- requirements
Module: snax_tcdm_bank_arbiter

Interface
REQ-001 Parameter NumWr, default 2, number of write-only requesters (1..8).
REQ-002 Parameter NumRd, default 2, number of read-only requesters (1..8).
REQ-003 Parameter AddrWidth, default 32, byte address width.
REQ-004 Parameter DataWidth, default 64, data width; StrbWidth = DataWidth/8.
REQ-005 Parameter MaxOutstanding, default 2, maximum in-flight reads (1..4).
REQ-006 Single clock clk_i; asynchronous active-low reset rst_ni.
REQ-007 Ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- wr_valid_i  in  NumWr  write request valid per requester
- wr_ready_o  out  NumWr  write request accepted
- wr_addr_i  in  NumWr x AddrWidth  write address
- wr_data_i  in  NumWr x DataWidth  write data
- wr_strb_i  in  NumWr x StrbWidth  byte enables
- rd_valid_i  in  NumRd  read request valid per requester
- rd_ready_o  out  NumRd  read request accepted
- rd_addr_i  in  NumRd x AddrWidth  read address
- rd_rsp_valid_o  out  NumRd  read response valid, one-hot
- rd_rsp_data_o  out  DataWidth  read data, shared by all read requesters
- mem_req_o  out  1  bank request
- mem_gnt_i  in  1  bank grant
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AddrWidth  bank address
- mem_wdata_o  out  DataWidth  bank write data
- mem_be_o  out  StrbWidth  bank byte enables (all ones for reads)
- mem_rvalid_i  in  1  bank read data valid, in request order
- mem_rdata_i  in  DataWidth  bank read data
- err_o  out  1  sticky protocol error

Function
REQ-008 Requester index space: writes 0..NumWr-1, reads NumWr..NumWr+NumRd-1; N = NumWr+NumRd.
REQ-009 A requester is eligible if its valid is high; a read requester is additionally eligible only when outstanding count < MaxOutstanding.
REQ-010 Round-robin: search starts at pointer ptr (reset 0), ascending with wrap; first eligible index is selected.
REQ-011 mem_req_o is high when a locked or selected requester exists; mem_we_o/addr/wdata/be are driven from it combinationally.
REQ-012 Handshake completes when mem_req_o && mem_gnt_i; the selected requester's ready_o equals mem_gnt_i in that cycle; all other ready_o are 0.
REQ-013 Lock: if mem_req_o is high and mem_gnt_i low, the selected index is registered and held on following cycles until granted, regardless of other valids or the pointer.
REQ-014 A locked requester that drops valid before grant is a protocol violation: set err_o, release the lock, and do not issue mem_req_o for it.
REQ-015 On handshake of index k, ptr <= (k+1) mod N next cycle; lock released.
REQ-016 Read handshake pushes the read index into an ID FIFO of depth MaxOutstanding; count increments.
REQ-017 mem_rvalid_i pops the FIFO head h; rd_rsp_valid_o[h] = 1 and rd_rsp_data_o = mem_rdata_i in the same cycle (zero added latency).
REQ-018 Simultaneous push and pop: count unchanged, FIFO order preserved; a pop frees a slot only from the next cycle.
REQ-019 mem_rvalid_i with empty FIFO: ignored, no rd_rsp_valid_o, err_o set.
REQ-020 Write handshakes never touch the FIFO; writes remain eligible when the FIFO is full.
REQ-021 At most one ready_o and at most one rd_rsp_valid_o high per cycle.

Reset
REQ-022 While rst_ni low: ptr=0, lock cleared, FIFO empty, count=0, err_o=0; mem_req_o, all ready_o and rd_rsp_valid_o 0.
REQ-023 Reset asserted mid-operation discards in-flight reads; rvalid after reset release with empty FIFO sets err_o per REQ-019.

Verification
REQ-024 wr_valid=2'b11, rd_valid=0, mem_gnt_i=1 for 4 cycles -> grants alternate wr0, wr1, wr0, wr1, mem_we_o=1.
REQ-025 rd0 valid addr 0x40, gnt low 3 cycles then high, wr0 raised in between -> mem_addr_o stays 0x40 all 4 cycles, rd_ready_o[0] only in cycle 4.
REQ-026 MaxOutstanding=2, rd0 and rd1 granted, no rvalid, rd0 valid again, wr1 valid -> rd0 blocked, wr1 granted; rvalid twice with 0xA,0xB -> rd_rsp_valid one-hot to rd0 then rd1 with 0xA then 0xB.
REQ-027 Full FIFO, rvalid and new rd valid same cycle -> read not granted that cycle, granted next cycle.
REQ-028 mem_rvalid_i pulse with empty FIFO -> err_o 1 and held until reset; no rd_rsp_valid_o.
REQ-029 Reset pulse with two reads outstanding -> count 0, ptr 0, err_o 0; next request at index 0 wins first.
